// File: rtl/mano_timing_gen.sv
// Timing-and-control generator for the MANO control unit.
// Holds the sequence counter (SC) and a latched opcode register, and
// decodes them into one-hot T and D strobes for the control logic.
module mano_timing_gen #(
  parameter int unsigned SC_W   = 4,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned SC_MAX = 2**SC_W - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 sc_clr,
  input  logic                 sc_inc,
  input  logic                 op_ld,
  input  logic [OP_W-1:0]      op_in,
  output logic [SC_W-1:0]      sc,
  output logic [2**SC_W-1:0]   t,
  output logic [2**OP_W-1:0]   d,
  output logic                 wrap
);

  localparam int unsigned N_T = 2**SC_W;
  localparam int unsigned N_D = 2**OP_W;
  localparam logic [SC_W-1:0] SC_TOP = SC_W'(SC_MAX);

  logic [OP_W-1:0] op_q;

  // Sequence counter: clear beats freeze beats increment; wrap pulses only
  // on a terminal-count increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc   <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (sc_clr) begin
        sc <= '0;
      end else if (run && sc_inc) begin
        if (sc == SC_TOP) begin
          sc   <= '0;
          wrap <= 1'b1;
        end else begin
          sc <= sc + 1'b1;
        end
      end
    end
  end

  // Opcode register: loads independently of run and the counter controls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if (op_ld) begin
      op_q <= op_in;
    end
  end

  // Timing decode straight off the registered count, no extra latency.
  always_comb begin
    t = '0;
    for (int unsigned k = 0; k < N_T; k++) begin
      t[k] = (sc == SC_W'(k));
    end
  end

  // Opcode decode of the latched opcode.
  always_comb begin
    d = '0;
    for (int unsigned k = 0; k < N_D; k++) begin
      d[k] = (op_q == OP_W'(k));
    end
  end

endmodule
